// File: rtl/exm_pkg.sv
// Shared types and constants for the exm_exec_mc execute stage.
// Optional iterative multiplier is enabled with the EXM_MUL_EN macro.
package exm_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_NOT  = 3'd5,
        ALU_MUL  = 3'd6,
        ALU_RSVD = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } exm_state_t;

    // Bit positions inside the packed {Z,N,C} flag register
    localparam int FLG_Z = 2;
    localparam int FLG_N = 1;
    localparam int FLG_C = 0;

endpackage

// File: rtl/exm_mul_seq.sv
// Radix-2 shift-add unsigned multiplier, one partial product per cycle, DATA_W cycles.
// Built only when EXM_MUL_EN is defined; product is final in the cycle done is high.
module exm_mul_seq #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic                 running_p0;
    logic [CNT_W-1:0]     cnt_p0;
    logic [2*DATA_W-1:0]  acc_p0;
    logic [2*DATA_W-1:0]  mcand_p0;
    logic [DATA_W-1:0]    mplier_p0;

    // product includes the current step so the last step is visible together with done
    assign product = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
    assign done    = running_p0 && (cnt_p0 == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_p0 <= 1'b0;
            cnt_p0     <= '0;
        end else if (abort) begin
            running_p0 <= 1'b0;
        end else if (start) begin
            running_p0 <= 1'b1;
            cnt_p0     <= '0;
        end else if (running_p0) begin
            cnt_p0 <= cnt_p0 + 1'b1;
            if (done) running_p0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            acc_p0    <= '0;
            mcand_p0  <= {{DATA_W{1'b0}}, a};
            mplier_p0 <= b;
        end else if (running_p0) begin
            acc_p0    <= product;
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
        end
    end

endmodule

// File: rtl/exm_exec_mc.sv
// Execute stage: operand muxes, single-cycle ALU, registered result/flags, flush.
// EXM_MUL_EN adds the iterative multiplier and the IDLE/MUL_BUSY/MUL_DONE FSM.
module exm_exec_mc
    import exm_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [OP_W-1:0]    i_alu_function,
    input  logic               i_imm,
    input  logic               i_inc_dec,
    input  logic               i_mov,
    input  logic               i_change_carry,
    input  logic               i_carry_value,
    input  logic               i_fwd1,
    input  logic               i_fwd2,
    input  logic [DATA_W-1:0]  i_data1,
    input  logic [DATA_W-1:0]  i_data2,
    input  logic [DATA_W-1:0]  i_immediate,
    input  logic [DATA_W-1:0]  i_data_wb,
    input  logic [RADDR_W-1:0] i_write_addr,
    input  logic               i_write_back,
    output logic               o_valid,
    output logic [DATA_W-1:0]  o_ex_result,
    output logic [RADDR_W-1:0] o_write_addr,
    output logic               o_write_back,
    output logic               o_zero_flag,
    output logic               o_negative_flag,
    output logic               o_carry_flag
);

    alu_op_t            op;
    logic [DATA_W-1:0]  op1, op2, alu_res;
    logic [DATA_W:0]    sum, diff;
    logic               upd_zn, upd_c, c_val, accept;
    logic [2:0]         flags_p1;

    assign op     = alu_op_t'(i_alu_function);
    assign op1    = i_fwd1 ? i_data_wb : i_data1;
    assign op2    = i_inc_dec ? DATA_W'(1) : i_imm ? i_immediate : i_fwd2 ? i_data_wb : i_data2;
    assign sum    = {1'b0, op1} + {1'b0, op2};
    // MSB of the widened difference is the unsigned borrow (op1 < op2)
    assign diff   = {1'b0, op1} - {1'b0, op2};
    assign accept = i_valid & o_ready & ~i_flush;

    assign o_zero_flag     = flags_p1[FLG_Z];
    assign o_negative_flag = flags_p1[FLG_N];
    assign o_carry_flag    = flags_p1[FLG_C];

    always_comb begin
        alu_res = op1;
        upd_zn  = 1'b0;
        upd_c   = 1'b0;
        c_val   = 1'b0;
        case (op)
            ALU_ADD: begin alu_res = sum[DATA_W-1:0];  upd_zn = 1'b1; upd_c = 1'b1; c_val = sum[DATA_W];  end
            ALU_SUB: begin alu_res = diff[DATA_W-1:0]; upd_zn = 1'b1; upd_c = 1'b1; c_val = diff[DATA_W]; end
            ALU_AND: begin alu_res = op1 & op2; upd_zn = 1'b1; end
            ALU_OR:  begin alu_res = op1 | op2; upd_zn = 1'b1; end
            ALU_NOT: begin alu_res = ~op1;      upd_zn = 1'b1; end
            default: alu_res = op1;
        endcase
        if (i_mov) begin
            alu_res = op2;
            upd_zn  = 1'b0;
            upd_c   = 1'b0;
        end
    end

`ifdef EXM_MUL_EN
    exm_state_t           state_p1;
    logic                 ready_p1, wb_p0, is_mul, mul_done;
    logic [RADDR_W-1:0]   wa_p0;
    logic [2*DATA_W-1:0]  mul_product;

    assign is_mul  = (op == ALU_MUL) & ~i_mov & ~i_change_carry;
    assign o_ready = ready_p1;

    exm_mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk     (i_clk),
        .rst_n   (i_reset),
        .start   (accept & is_mul),
        .abort   (i_flush),
        .a       (op1),
        .b       (op2),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign o_ready = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_valid      <= 1'b0;
            o_ex_result  <= '0;
            o_write_addr <= '0;
            o_write_back <= 1'b0;
            flags_p1     <= '0;
`ifdef EXM_MUL_EN
            state_p1     <= IDLE;
            ready_p1     <= 1'b1;
            wa_p0        <= '0;
            wb_p0        <= 1'b0;
`endif
        end else begin
            o_valid      <= 1'b0;
            o_write_back <= 1'b0;
            if (i_flush) begin
`ifdef EXM_MUL_EN
                state_p1 <= IDLE;
                ready_p1 <= 1'b1;
`endif
            end
`ifdef EXM_MUL_EN
            else if (state_p1 == MUL_BUSY) begin
                if (mul_done) begin
                    state_p1        <= MUL_DONE;
                    o_valid         <= 1'b1;
                    o_ex_result     <= mul_product[DATA_W-1:0];
                    o_write_addr    <= wa_p0;
                    o_write_back    <= wb_p0;
                    flags_p1[FLG_Z] <= (mul_product[DATA_W-1:0] == '0);
                    flags_p1[FLG_N] <= mul_product[DATA_W-1];
                    flags_p1[FLG_C] <= |mul_product[2*DATA_W-1:DATA_W];
                end
            end else if (state_p1 == MUL_DONE) begin
                state_p1 <= IDLE;
                ready_p1 <= 1'b1;
            end else if (accept && is_mul) begin
                state_p1 <= MUL_BUSY;
                ready_p1 <= 1'b0;
                wa_p0    <= i_write_addr;
                wb_p0    <= i_write_back;
            end
`endif
            else if (accept) begin
                o_valid      <= 1'b1;
                o_write_addr <= i_write_addr;
                if (i_change_carry) begin
                    flags_p1[FLG_C] <= i_carry_value;
                end else begin
                    o_ex_result  <= alu_res;
                    o_write_back <= i_write_back;
                    if (upd_zn) begin
                        flags_p1[FLG_Z] <= (alu_res == '0);
                        flags_p1[FLG_N] <= alu_res[DATA_W-1];
                    end
                    if (upd_c) flags_p1[FLG_C] <= c_val;
                end
            end
        end
    end

endmodule
